evg_heartbeat_timer: RTL
========================

// Module: evg_heartbeat_timer
// PURPOSE
//  Upstream timing source for the event generator. Runs in the EVG transmit clock domain.
//  Produces evgHeartbeatRequest and evgSequenceStart: single-cycle pulses that the EVG
//  turns into distributed-bus heartbeat and sequencer starts.
//  Free-running or PPS-aligned; heartbeat interval, sequence divisor and sequence delay
//  are programmable. Config inputs are already synchronous to evgTxClk.
// PARAMETERS
//  COUNTER_WIDTH   32     width of the interval and delay counters (clock cycles)
//  DIVISOR_WIDTH   8      width of the heartbeats-per-sequence divisor
//  DEBUG           "false" value of the mark_debug attribute on outputs
// PORTS
//  evgTxClk              in   1   sole clock; EVG transmit clock
//  evgReset              in   1   asynchronous, active-high reset
//  evgConfigStrobe       in   1   1-cycle pulse; latch all config fields below
//  evgConfigMode         in   2   0=STOP 1=FREE_RUN 2=PPS_ALIGNED 3=reserved(treated as STOP)
//  evgHeartbeatInterval  in   CW  heartbeat period in cycles (I)
//  evgSequenceDivisor    in   DW  sequence start every D heartbeats; 0 disables sequences
//  evgSequenceDelay      in   CW  cycles from heartbeat pulse to sequence pulse (L)
//  evgPPSmarker          in   1   1-cycle PPS pulse, already in evgTxClk domain
//  evgClearStatus        in   1   1-cycle pulse; clears evgPPSmisalign
//  evgHeartbeatRequest   out  1   1-cycle heartbeat pulse, registered
//  evgSequenceStart      out  1   1-cycle sequence start pulse, registered
//  evgRunning            out  1   state==RUN
//  evgArmed              out  1   state==ARMED (waiting for PPS)
//  evgPPSmisalign        out  1   sticky: PPS arrived off heartbeat phase while in RUN
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters and latched config 0.
//  Config latch and clamping:
//   - Effective I = max(I,2).
//   - Effective L = min(L, I-1).
//   - The strobe overrides anything in progress: counters clear, pending sequence is cancelled.
//  FSM states are IDLE, ARMED and RUN. Transitions on evgConfigStrobe:
//   - Mode STOP: go to IDLE.
//   - Mode FREE_RUN: go to RUN.
//   - Mode PPS_ALIGNED: go to ARMED.
//   - ARMED -> RUN on evgPPSmarker.
//  RUN entry and heartbeat timing:
//   - Call the strobe or PPS cycle that causes RUN entry t0.
//   - First evgHeartbeatRequest is asserted at t0+1; later ones at t0+1+k*I.
//   - hbCount loads I-1 on every pulse and counts down; the pulse fires when it reaches 0.
//  Sequence divisor:
//   - divCount counts heartbeats modulo D; the first heartbeat after RUN entry is index 0.
//   - Heartbeats with index%D==0 trigger a sequence.
//  Sequence delay:
//   - evgSequenceStart asserts L cycles after the triggering heartbeat pulse.
//   - L=0 gives the same cycle as the heartbeat.
//   - Because L<=I-1, at most one sequence is ever pending.
//  PPS handling in RUN, PPS_ALIGNED mode:
//   - PPS coinciding with a heartbeat pulse (same cycle) is aligned.
//   - Any other PPS sets evgPPSmisalign.
//   - The phase is NOT corrected; software re-strobes to realign.
//   - In FREE_RUN mode PPS is ignored.
//  PPS and status edge cases:
//   - PPS in the same cycle as a config strobe: the strobe wins and the PPS is ignored.
//   - Clear and set of misalign in the same cycle: set wins.
//  Leaving RUN:
//   - Moving to IDLE or ARMED drops both pulse outputs from the next cycle.
//   - A pending sequence is discarded.
//  Asynchronous reset mid-run: outputs clear immediately; config must be re-strobed.
//  Width rules:
//   - Counters are COUNTER_WIDTH unsigned with no wrap, since they are reloaded before underflow.
//   - divCount is DIVISOR_WIDTH and wraps at D-1.
//  Latency: every output is a flop; no combinational path from input to output.
// STRUCTURE
//  evg_timing_defs.vh holds shared constants:
//   - Mode encodings MODE_STOP, MODE_FREE_RUN, MODE_PPS_ALIGNED.
//   - FSM state encodings.
//   - Minimum interval constant (2).
//  Sub-module evg_pulse_delay: loadable down-counter one-shot.
//   - Inputs: load pulse + delay value.
//   - Output: 1-cycle pulse after delay (0 = same cycle); clear input cancels.
//   - Instantiated once for the sequence delay.
// TESTING
//  1 FREE_RUN, I=10, D=0: strobe at t0 -> heartbeat at t0+1, t0+11, t0+21; evgSequenceStart never asserts.
//  2 FREE_RUN, I=10, D=3, L=4: strobe at t0 -> heartbeats t0+1,+11,+21,+31; sequence at t0+5, t0+35 only.
//  3 PPS_ALIGNED, I=125, D=1, L=0: strobe -> evgArmed=1, no pulses; PPS at tp -> heartbeat+sequence at tp+1, evgRunning=1.
//  4 PPS_ALIGNED RUN, I=100: PPS 50 cycles after a heartbeat -> evgPPSmisalign=1, phase unchanged;
//    evgClearStatus -> 0; PPS on a heartbeat cycle -> stays 0.
//  5 Clamps: I=1, L=50 -> heartbeats every 2 cycles, sequence 1 cycle after each heartbeat.
//  6 Mid-run: STOP strobe while a sequence is pending (L=8, 3 cycles in) -> no sequence pulse, all outputs 0.
//    Separately, asserting evgReset during RUN -> all outputs 0 same cycle and state IDLE after release.

Source files
------------

// File: rtl/evg_heartbeat_timer_pkg.sv
// Shared encodings and constants for the EVG heartbeat timer.
// The latched mode value and the FSM state use these enums.
package evg_heartbeat_timer_pkg;

  typedef enum logic [1:0] {
    MODE_STOP        = 2'd0,
    MODE_FREE_RUN    = 2'd1,
    MODE_PPS_ALIGNED = 2'd2,
    MODE_RESERVED    = 2'd3
  } evg_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } evg_state_e;

  localparam int unsigned MIN_INTERVAL = 2;

endpackage

// File: rtl/evg_pulse_delay.sv
// Loadable down-counter one-shot: emits a 1-cycle registered pulse delay_i cycles after load_i.
// A delay of 0 pulses in the cycle after the load edge. load_i has priority over clear_i.
module evg_pulse_delay #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] delay_i,
  output logic             pulse_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (load_i) begin
      cnt_d   = delay_i;
      pulse_d = (delay_i == '0);
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d   = cnt_q - ONE;
      pulse_d = (cnt_q == ONE);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/evg_heartbeat_timer.sv
// EVG heartbeat / sequence-start pulse source, free-running or aligned to a PPS marker.
// Every output is a flop; the sequence delay lives in evg_pulse_delay.
module evg_heartbeat_timer
  import evg_heartbeat_timer_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned DIVISOR_WIDTH = 8,
  parameter string       DEBUG         = "false"
) (
  input  logic                     evgTxClk,
  input  logic                     evgReset,
  input  logic                     evgConfigStrobe,
  input  logic [1:0]               evgConfigMode,
  input  logic [COUNTER_WIDTH-1:0] evgHeartbeatInterval,
  input  logic [DIVISOR_WIDTH-1:0] evgSequenceDivisor,
  input  logic [COUNTER_WIDTH-1:0] evgSequenceDelay,
  input  logic                     evgPPSmarker,
  input  logic                     evgClearStatus,
  output logic                     evgHeartbeatRequest,
  output logic                     evgSequenceStart,
  output logic                     evgRunning,
  output logic                     evgArmed,
  output logic                     evgPPSmisalign
);

  localparam logic [COUNTER_WIDTH-1:0] C_ONE = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] C_MIN = COUNTER_WIDTH'(MIN_INTERVAL);
  localparam logic [DIVISOR_WIDTH-1:0] D_ONE = DIVISOR_WIDTH'(1);

  evg_state_e                 state_q, state_d;
  evg_mode_e                  mode_q;
  logic [COUNTER_WIDTH-1:0]   int_q, dly_q, hb_cnt_q, hb_cnt_d;
  logic [DIVISOR_WIDTH-1:0]   div_q, div_cnt_q, div_cnt_d;
  logic                       hb_q, hb_d, run_q, arm_q, mis_q, mis_d;
  logic [COUNTER_WIDTH-1:0]   cfg_int, cfg_dly, cur_int, cur_dly;
  logic [DIVISOR_WIDTH-1:0]   cur_div, hb_idx;
  logic                       run_entry, mis_set, seq_load, seq_clr, seq_pulse;

  // A strobe that enters RUN must time its first heartbeat from the new fields, not the latched ones.
  always_comb begin
    cfg_int = (evgHeartbeatInterval < C_MIN) ? C_MIN : evgHeartbeatInterval;
    cfg_dly = (evgSequenceDelay > cfg_int - C_ONE) ? cfg_int - C_ONE : evgSequenceDelay;
    cur_int = evgConfigStrobe ? cfg_int : int_q;
    cur_dly = evgConfigStrobe ? cfg_dly : dly_q;
    cur_div = evgConfigStrobe ? evgSequenceDivisor : div_q;
  end

  always_ff @(posedge evgTxClk or posedge evgReset) begin
    if (evgReset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (evgConfigStrobe) begin
      case (evgConfigMode)
        MODE_FREE_RUN:    state_d = ST_RUN;
        MODE_PPS_ALIGNED: state_d = ST_ARMED;
        default:          state_d = ST_IDLE;
      endcase
    end else if (state_q == ST_ARMED && evgPPSmarker) begin
      state_d = ST_RUN;
    end
  end

  assign run_entry = (state_d == ST_RUN) && (evgConfigStrobe || state_q == ST_ARMED);

  always_comb begin
    hb_d      = 1'b0;
    seq_load  = 1'b0;
    hb_cnt_d  = hb_cnt_q;
    div_cnt_d = div_cnt_q;
    hb_idx    = run_entry ? '0 : div_cnt_q;
    if (run_entry || (state_q == ST_RUN && !evgConfigStrobe && hb_cnt_q == '0)) begin
      hb_d      = 1'b1;
      hb_cnt_d  = cur_int - C_ONE;
      seq_load  = (cur_div != '0) && (hb_idx == '0);
      div_cnt_d = (hb_idx >= cur_div - D_ONE) ? '0 : hb_idx + D_ONE;
    end else if (evgConfigStrobe) begin
      hb_cnt_d  = '0;
      div_cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      hb_cnt_d = hb_cnt_q - C_ONE;
    end
    seq_clr = evgConfigStrobe || (state_d != ST_RUN);
    // Alignment is judged against the heartbeat currently on the output.
    mis_set = !evgConfigStrobe && (state_q == ST_RUN) && (mode_q == MODE_PPS_ALIGNED)
              && evgPPSmarker && !hb_q;
    mis_d   = mis_set ? 1'b1 : (evgClearStatus ? 1'b0 : mis_q);
  end

  always_ff @(posedge evgTxClk or posedge evgReset) begin
    if (evgReset) begin
      mode_q    <= MODE_STOP;
      int_q     <= '0;
      dly_q     <= '0;
      div_q     <= '0;
      hb_cnt_q  <= '0;
      div_cnt_q <= '0;
      hb_q      <= 1'b0;
      run_q     <= 1'b0;
      arm_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      if (evgConfigStrobe) begin
        mode_q <= evg_mode_e'(evgConfigMode);
        int_q  <= cfg_int;
        dly_q  <= cfg_dly;
        div_q  <= evgSequenceDivisor;
      end
      hb_cnt_q  <= hb_cnt_d;
      div_cnt_q <= div_cnt_d;
      hb_q      <= hb_d;
      run_q     <= (state_d == ST_RUN);
      arm_q     <= (state_d == ST_ARMED);
      mis_q     <= mis_d;
    end
  end

  evg_pulse_delay #(
    .WIDTH(COUNTER_WIDTH)
  ) u_seq_delay (
    .clk_i   (evgTxClk),
    .rst_i   (evgReset),
    .load_i  (seq_load),
    .clear_i (seq_clr),
    .delay_i (cur_dly),
    .pulse_o (seq_pulse)
  );

  assign evgHeartbeatRequest = hb_q;
  assign evgSequenceStart    = seq_pulse;
  assign evgRunning          = run_q;
  assign evgArmed            = arm_q;
  assign evgPPSmisalign      = mis_q;

  // Registered copy of the outputs that the logic analyser can probe by name.
  if (DEBUG == "true") begin : g_mark_debug
    (* mark_debug = "true" *) logic [4:0] dbg_outs_q;
    always_ff @(posedge evgTxClk) dbg_outs_q <= {hb_q, seq_pulse, run_q, arm_q, mis_q};
  end

endmodule
